// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall controller bundle: ID/EX hazard inputs, memory handshake and
// per-stage pipeline register controls.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    // Hazard detection inputs from ID and EX
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_rt_used_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rt_i;
    logic             branch_taken_i;

    // Data-memory handshake from/to the EX/MEM stage
    logic [1:0]       mem_ctrl_i;
    logic             mem_ack_i;
    logic             mem_req_o;

    // Pipeline register controls
    logic             pc_enable_o;
    logic             ifid_enable_o;
    logic             ifid_flush_o;
    logic             idex_enable_o;
    logic             idex_flush_o;
    logic             exmem_enable_o;
    logic             memwb_enable_o;
    logic             memwb_flush_o;

    // Status
    logic             mem_error_o;
    logic [CNT_W-1:0] stall_count_o;

    // Controller side
    modport master (
        input  id_rs_i, id_rt_i, id_rt_used_i, ex_memread_i, ex_rt_i,
        input  branch_taken_i, mem_ctrl_i, mem_ack_i,
        output mem_req_o, pc_enable_o, ifid_enable_o, ifid_flush_o,
        output idex_enable_o, idex_flush_o, exmem_enable_o,
        output memwb_enable_o, memwb_flush_o, mem_error_o, stall_count_o
    );

    // Pipeline / memory side
    modport slave (
        output id_rs_i, id_rt_i, id_rt_used_i, ex_memread_i, ex_rt_i,
        output branch_taken_i, mem_ctrl_i, mem_ack_i,
        input  mem_req_o, pc_enable_o, ifid_enable_o, ifid_flush_o,
        input  idex_enable_o, idex_flush_o, exmem_enable_o,
        input  memwb_enable_o, memwb_flush_o, mem_error_o, stall_count_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central hazard and stall controller for the 5-stage pipeline.
// Priority: reset > memory freeze/error > load-use stall > branch flush.
// Stage controls and mem_req_o are combinational from state and inputs;
// FSM state, timeout counter, stall counter and error flag are registered.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                  clock_i,
    input  logic                  rst_i,
    pipeline_ctrl_if.master       bus
);

    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               err_q, err_d;

    logic               acc_c;
    logic               load_use_c;
    logic               freeze_c;
    logic               mem_req_c;
    logic               pc_enable_c;
    logic               ifid_enable_c;
    logic               ifid_flush_c;
    logic               idex_enable_c;
    logic               idex_flush_c;
    logic               exmem_enable_c;
    logic               memwb_enable_c;
    logic               memwb_flush_c;

    // Access request and load-use detection on the raw ID/EX fields
    always_comb begin
        acc_c      = (bus.mem_ctrl_i != 2'b00);
        load_use_c = bus.ex_memread_i && (bus.ex_rt_i != 5'd0) &&
                     ((bus.ex_rt_i == bus.id_rs_i) ||
                      (bus.id_rt_used_i && (bus.ex_rt_i == bus.id_rt_i)));
    end

    // State, timeout counter, stall counter and sticky error
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    // Next state plus per-stage enables/flushes and memory request
    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        err_d          = err_q;
        freeze_c       = 1'b0;
        mem_req_c      = 1'b0;
        pc_enable_c    = 1'b1;
        ifid_enable_c  = 1'b1;
        ifid_flush_c   = 1'b0;
        idex_enable_c  = 1'b1;
        idex_flush_c   = 1'b0;
        exmem_enable_c = 1'b1;
        memwb_enable_c = 1'b1;
        memwb_flush_c  = 1'b0;

        if (rst_i) begin
            // Abandon any access; bubble every stage register
            state_d        = ST_IDLE;
            tmo_d          = '0;
            err_d          = 1'b0;
            pc_enable_c    = 1'b0;
            ifid_enable_c  = 1'b0;
            ifid_flush_c   = 1'b1;
            idex_enable_c  = 1'b0;
            idex_flush_c   = 1'b1;
            exmem_enable_c = 1'b0;
            memwb_enable_c = 1'b0;
            memwb_flush_c  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc_c) begin
                        mem_req_c = 1'b1;
                        if (!bus.mem_ack_i) begin
                            freeze_c = 1'b1;
                            state_d  = ST_BUSY;
                            tmo_d    = '0;
                        end
                    end
                end
                ST_BUSY: begin
                    mem_req_c = 1'b1;
                    if (bus.mem_ack_i) begin
                        // Release now; EX/MEM loads the next instruction
                        state_d = ST_IDLE;
                        tmo_d   = '0;
                    end else begin
                        freeze_c = 1'b1;
                        if (tmo_q == TMO_LAST) begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                        end else begin
                            tmo_d = tmo_q + TMO_W'(1);
                        end
                    end
                end
                ST_ERROR: begin
                    // Dead until reset: hold everything, keep WB bubbling
                    pc_enable_c    = 1'b0;
                    ifid_enable_c  = 1'b0;
                    idex_enable_c  = 1'b0;
                    exmem_enable_c = 1'b0;
                    memwb_enable_c = 1'b0;
                    memwb_flush_c  = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end
            endcase

            if (state_q != ST_ERROR) begin
                if (freeze_c) begin
                    // Hold IF..MEM, let WB advance with a bubble
                    pc_enable_c    = 1'b0;
                    ifid_enable_c  = 1'b0;
                    idex_enable_c  = 1'b0;
                    exmem_enable_c = 1'b0;
                    memwb_enable_c = 1'b1;
                    memwb_flush_c  = 1'b1;
                end else if (load_use_c) begin
                    // Hold PC and IF/ID, inject a bubble into ID/EX
                    pc_enable_c   = 1'b0;
                    ifid_enable_c = 1'b0;
                    idex_flush_c  = 1'b1;
                end else if (bus.branch_taken_i) begin
                    ifid_flush_c = 1'b1;
                end
            end
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_comb begin
        stall_d = stall_q;
        if (rst_i) begin
            stall_d = '0;
        end else if (!pc_enable_c && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    assign bus.mem_req_o      = mem_req_c;
    assign bus.pc_enable_o    = pc_enable_c;
    assign bus.ifid_enable_o  = ifid_enable_c;
    assign bus.ifid_flush_o   = ifid_flush_c;
    assign bus.idex_enable_o  = idex_enable_c;
    assign bus.idex_flush_o   = idex_flush_c;
    assign bus.exmem_enable_o = exmem_enable_c;
    assign bus.memwb_enable_o = memwb_enable_c;
    assign bus.memwb_flush_o  = memwb_flush_c;
    assign bus.mem_error_o    = err_q;
    assign bus.stall_count_o  = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random traffic, each cycle
// compared against a cycle-level behavioural model of the controller.
module tb_pipeline_ctrl;

    localparam int unsigned TMO  = 4;
    localparam int unsigned CW   = 6;
    localparam int          MAXV = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
        .clock_i (clk),
        .rst_i   (rst),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: 0 = no access outstanding, 1 = waiting on memory, 2 = dead
    int m_mode;
    int m_busy;
    bit m_err;
    int m_stall;

    // Expected {req,pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,memwb_en,memwb_fl,err}
    function automatic logic [9:0] ref_ctl();
        logic req, pc, ie, ifl, xe, xfl, me, we, wfl;
        bit   acc, lu, frz;
        acc = (bus.mem_ctrl_i != 2'b00);
        lu  = bus.ex_memread_i && (bus.ex_rt_i != 5'd0) &&
              ((bus.ex_rt_i == bus.id_rs_i) ||
               (bus.id_rt_used_i && (bus.ex_rt_i == bus.id_rt_i)));
        req = 0; pc = 1; ie = 1; ifl = 0; xe = 1; xfl = 0; me = 1; we = 1; wfl = 0;
        if (rst) begin
            pc = 0; ie = 0; xe = 0; me = 0; we = 0;
            ifl = 1; xfl = 1; wfl = 1;
        end else if (m_mode == 2) begin
            pc = 0; ie = 0; xe = 0; me = 0; we = 0; wfl = 1;
        end else begin
            req = (m_mode == 1) || acc;
            frz = req && !bus.mem_ack_i;
            if (frz) begin
                pc = 0; ie = 0; xe = 0; me = 0; wfl = 1;
            end else if (lu) begin
                pc = 0; ie = 0; xfl = 1;
            end else if (bus.branch_taken_i) begin
                ifl = 1;
            end
        end
        return {req, pc, ie, ifl, xe, xfl, me, we, wfl, logic'(m_err)};
    endfunction

    task automatic model_step(input logic pc_exp);
        if (rst) begin
            m_mode = 0; m_busy = 0; m_err = 0; m_stall = 0;
        end else begin
            if (!pc_exp) m_stall = (m_stall + 1 > MAXV) ? MAXV : m_stall + 1;
            case (m_mode)
                0: if (bus.mem_ctrl_i != 2'b00 && !bus.mem_ack_i) begin
                       m_mode = 1; m_busy = 0;
                   end
                1: if (bus.mem_ack_i) m_mode = 0;
                   else begin
                       m_busy++;
                       if (m_busy == TMO) begin m_mode = 2; m_err = 1; end
                   end
                default: ;
            endcase
        end
    endtask

    // One clock: settle, compare, advance model, step past the edge
    task automatic cyc(input string tag);
        logic [9:0] exp, got;
        #2;
        exp = ref_ctl();
        got = {bus.mem_req_o, bus.pc_enable_o, bus.ifid_enable_o, bus.ifid_flush_o,
               bus.idex_enable_o, bus.idex_flush_o, bus.exmem_enable_o,
               bus.memwb_enable_o, bus.memwb_flush_o, bus.mem_error_o};
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s ctl observed %b expected %b", tag, got, exp);
        end
        vectors++;
        assert (bus.stall_count_o === CW'(m_stall)) else begin
            miscompares++;
            $error("FAIL %s stall_count observed %0d expected %0d", tag, bus.stall_count_o, m_stall);
        end
        model_step(exp[8]);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int rs, input int rt, input bit used, input bit mr,
                          input int xrt, input bit br, input int mctl, input bit ack);
        bus.id_rs_i        = 5'(rs);
        bus.id_rt_i        = 5'(rt);
        bus.id_rt_used_i   = used;
        bus.ex_memread_i   = mr;
        bus.ex_rt_i        = 5'(xrt);
        bus.branch_taken_i = br;
        bus.mem_ctrl_i     = 2'(mctl);
        bus.mem_ack_i      = ack;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        m_mode = 0; m_busy = 0; m_err = 0; m_stall = 0;
        cyc("reset");
        rst = 1'b0;
        cyc("idle");

        // Load-use on rs, on used rt, ignored for r0 and unused rt
        set_in(8, 0, 0, 1, 8, 0, 0, 0); cyc("lu_rs");
        set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("lu_after");
        set_in(0, 3, 0, 1, 0, 0, 0, 0); cyc("lu_r0");
        set_in(1, 9, 1, 1, 9, 0, 0, 0); cyc("lu_rt");
        set_in(1, 9, 0, 1, 9, 0, 0, 0); cyc("lu_rt_unused");
        set_in(8, 0, 0, 0, 8, 0, 0, 0); cyc("no_load");

        // Multi-cycle load, ack three cycles after the request
        set_in(0, 0, 0, 0, 0, 0, 2, 0); cyc("ml_req");
        cyc("ml_wait1");
        cyc("ml_wait2");
        bus.mem_ack_i = 1'b1;           cyc("ml_ack");
        set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("ml_done");

        // Single-cycle store, and read+write as one access
        set_in(0, 0, 0, 0, 0, 0, 1, 1); cyc("sc_store");
        set_in(0, 0, 0, 0, 0, 0, 3, 1); cyc("sc_rw");
        set_in(0, 0, 0, 0, 0, 1, 0, 0); cyc("branch");

        // Freeze dominates load-use and branch; load-use dominates branch
        set_in(4, 0, 0, 1, 4, 1, 3, 0); cyc("pri_freeze0");
        cyc("pri_freeze1");
        bus.mem_ack_i = 1'b1;           cyc("pri_release");
        set_in(5, 0, 0, 1, 5, 1, 0, 0); cyc("pri_lu_br");

        // Timeout into ERROR, then hold long enough to saturate the counter
        set_in(0, 0, 0, 0, 0, 0, 2, 0); cyc("to_req");
        for (int i = 0; i < int'(TMO); i++) cyc("to_busy");
        for (int i = 0; i < 70; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
            cyc("err_hold");
        end
        rst = 1'b1; cyc("err_reset");
        rst = 1'b0;

        // Ack arriving on the last allowed BUSY cycle wins
        set_in(0, 0, 0, 0, 0, 0, 2, 0); cyc("late_req");
        for (int i = 0; i < int'(TMO) - 1; i++) cyc("late_busy");
        bus.mem_ack_i = 1'b1;           cyc("late_ack");
        set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("late_idle");

        // Reset in the middle of an access
        set_in(0, 0, 0, 0, 0, 0, 2, 0); cyc("mid_req");
        cyc("mid_busy");
        rst = 1'b1;                     cyc("mid_reset");
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0); cyc("mid_after");

        // Random traffic with narrow register fields to provoke collisions
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                   ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 2) == 0));
            cyc("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and stall controller for the 5-stage pipeline.
- Generates per-stage enable/flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and taken-branch flushes in ID.
- Sequences multi-cycle data-memory accesses from the EX/MEM stage via a req/ack handshake, with a timeout watchdog and a stall-cycle counter.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in BUSY before declaring a memory error (>=2)
CNT_W, 32, width of stall_count_o (saturating)

Ports:
clock_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
id_rs_i  in  5  rs field of instruction in ID
id_rt_i  in  5  rt field of instruction in ID
id_rt_used_i  in  1  ID instruction reads rt as a source
ex_memread_i  in  1  instruction in EX is a load
ex_rt_i  in  5  destination rt of instruction in EX
branch_taken_i  in  1  branch/jump resolved taken in ID this cycle
mem_ctrl_i  in  2  EX/MEM control_MEM: bit1 read, bit0 write
mem_ack_i  in  1  data memory completes current access
mem_req_o  out  1  data memory request
pc_enable_o  out  1  PC update enable
ifid_enable_o  out  1  IF/ID enable
ifid_flush_o  out  1  IF/ID flush (insert nop)
idex_enable_o  out  1  ID/EX enable
idex_flush_o  out  1  ID/EX flush
exmem_enable_o  out  1  EX/MEM enable
memwb_enable_o  out  1  MEM/WB enable
memwb_flush_o  out  1  MEM/WB flush
mem_error_o  out  1  sticky timeout error
stall_count_o  out  CNT_W  cycles with pc_enable_o=0

Behaviour:
- Clock clock_i; reset rst_i is synchronous and active-high.
- Reset cycle (rst_i=1):
  - Next state IDLE; timeout counter, stall_count_o and mem_error_o cleared.
  - Outputs that cycle: all enables 0, all flushes 1, mem_req_o 0.
  - Reset mid-access abandons the request; mem_req_o drops in the reset cycle.
- FSM states: IDLE, BUSY, ERROR. Enables, flushes and mem_req_o are combinational from state and inputs; counters, error and state are registered.
- Memory sequencing (highest priority); acc = mem_ctrl_i != 0:
  - IDLE, acc=0: no memory stall.
  - IDLE, acc=1, mem_ack_i=1: single-cycle access, no stall, mem_req_o=1, stay IDLE.
  - IDLE, acc=1, mem_ack_i=0: mem_req_o=1; go BUSY.
  - IDLE with mem_ctrl_i=2'b11: treated as one access.
  - BUSY, mem_ack_i=0: mem_req_o=1; memory freeze (all enables 0 except memwb; memwb_enable_o=1, memwb_flush_o=1 to bubble WB).
  - BUSY, mem_ack_i=1: mem_req_o=1; freeze released this cycle; go IDLE; EX/MEM captures next instruction, so no duplicate request.
  - BUSY timeout: counter counts BUSY cycles. When it reaches TIMEOUT_CYCLES-1 with no ack, go ERROR and set mem_error_o=1. An ack arriving in that same cycle wins: go IDLE, no error.
  - ERROR: mem_req_o=0; all enables 0; memwb_flush_o=1. Exit only via reset.
- Load-use hazard, evaluated only when no memory freeze:
  - Condition: ex_memread_i & ex_rt_i!=0 & (ex_rt_i==id_rs_i | (id_rt_used_i & ex_rt_i==id_rt_i)).
  - Action: pc_enable_o=0, ifid_enable_o=0, idex_flush_o=1; exmem/memwb enables 1.
  - Lasts exactly one cycle per load; the bubble clears ex_memread_i.
- Branch flush, evaluated only when no freeze and no load-use: branch_taken_i -> ifid_flush_o=1, all enables 1.
  - branch_taken_i is ignored during load-use; ID re-resolves the branch next cycle.
- Default (no event): all enables 1, all flushes 0.
- Flushes are level signals valid for exactly the event cycle; a flush overrides enable at the register.
- stall_count_o: +1 on every non-reset cycle with pc_enable_o=0; saturates at all-ones.
- mem_error_o: stays 1 until reset.

Test Plan:
1. Load-use: ex_memread_i=1, ex_rt_i=8, id_rs_i=8 -> one cycle with pc_enable_o=0, ifid_enable_o=0, idex_flush_o=1; stall_count_o 0->1. Repeat with ex_rt_i=0 -> no stall.
2. Multi-cycle load: mem_ctrl_i=2'b10, mem_ack_i rises 3 cycles later -> mem_req_o high 4 cycles; 3 freeze cycles (pc/ifid/idex/exmem enables 0, memwb_flush_o=1); release on ack cycle; stall_count_o=3.
3. Single-cycle ack: mem_ctrl_i=2'b01 with mem_ack_i=1 same cycle -> no stall, FSM stays IDLE.
4. Priority: memory freeze with simultaneous load-use and branch_taken_i -> only freeze pattern, ifid_flush_o=0. Load-use with branch_taken_i -> idex_flush_o=1, ifid_flush_o=0.
5. Timeout: TIMEOUT_CYCLES=4, no ack -> ERROR after 4 BUSY cycles, mem_error_o=1, mem_req_o=0, pipeline frozen. Ack on 4th cycle -> IDLE, no error.
6. Reset mid-BUSY: rst_i pulse -> mem_req_o=0 and flushes=1 in reset cycle; then IDLE, mem_error_o=0, stall_count_o=0.
